// File: rtl/pipe_dmem_arbiter.sv
// Arbitrates one shared data-memory port between the MEM-stage CPU access and a
// 1-4 beat IO burst master, with starvation-bounded IO priority and read-return routing.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | port free; CPU or IO beat 0 granted combinationally
// S_IO_BURST | IO beats 1..len in progress; CPU stalled if requesting
module pipe_dmem_arbiter #(
  parameter int IO_MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_stall,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_rvalid,
  input  logic        i_io_req,
  input  logic        i_io_we,
  input  logic [31:0] i_io_addr,
  input  logic [1:0]  i_io_len,
  input  logic [31:0] i_io_wdata,
  output logic        o_io_ack,
  output logic        o_io_done,
  output logic [31:0] o_io_rdata,
  output logic        o_io_rvalid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [15:0] o_cpu_conflicts
);

  localparam int WW = (IO_MAX_WAIT < 1) ? 1 : $clog2(IO_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(IO_MAX_WAIT);

  typedef enum logic {S_IDLE, S_IO_BURST} state_t;

  state_t        r_state;
  logic [1:0]    r_beat;
  logic [1:0]    r_len;
  logic [31:0]   r_base;
  logic          r_we;
  logic [WW-1:0] r_wait_cnt;
  logic          r_rd_valid;
  logic          r_rd_tag;
  logic [15:0]   r_conflicts;

  logic        w_idle;
  logic        w_in_burst;
  logic        w_cpu_grant;
  logic        w_io_start;
  logic        w_cpu_rd;
  logic        w_io_rd;
  logic [31:0] w_beat_addr;

  // Grants are gated by reset so an asserted reset silences the port at once.
  assign w_idle      = (r_state == S_IDLE) && !i_rst;
  assign w_in_burst  = (r_state == S_IO_BURST) && !i_rst;
  assign w_cpu_grant = w_idle && i_cpu_req && (!i_io_req || (r_wait_cnt < WAIT_MAX));
  assign w_io_start  = w_idle && i_io_req && (!i_cpu_req || (r_wait_cnt >= WAIT_MAX));
  assign w_beat_addr = r_base + {28'd0, r_beat, 2'b00};
  assign w_cpu_rd    = w_cpu_grant && !i_cpu_we;
  assign w_io_rd     = (w_io_start && !i_io_we) || (w_in_burst && !r_we);

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    if (w_cpu_grant) begin
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_io_start) begin
      o_mem_we    = i_io_we;
      o_mem_addr  = i_io_addr;
      o_mem_wdata = i_io_wdata;
    end else if (w_in_burst) begin
      o_mem_we    = r_we;
      o_mem_addr  = w_beat_addr;
      o_mem_wdata = i_io_wdata;
    end
  end

  assign o_cpu_stall     = i_cpu_req && !w_cpu_grant && !i_rst;
  assign o_io_ack        = w_io_start || w_in_burst;
  assign o_io_done       = (w_io_start && (i_io_len == 2'd0)) || (w_in_burst && (r_beat == r_len));
  assign o_cpu_rdata     = i_mem_rdata;
  assign o_io_rdata      = i_mem_rdata;
  assign o_cpu_rvalid    = r_rd_valid && !r_rd_tag;
  assign o_io_rvalid     = r_rd_valid && r_rd_tag;
  assign o_cpu_conflicts = r_conflicts;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_len       <= 2'd0;
      r_base      <= 32'd0;
      r_we        <= 1'b0;
      r_wait_cnt  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_tag    <= 1'b0;
      r_conflicts <= 16'd0;
    end else begin
      r_rd_valid <= w_cpu_rd || w_io_rd;
      r_rd_tag   <= w_io_rd;

      if (o_cpu_stall && (r_conflicts != 16'hFFFF))
        r_conflicts <= r_conflicts + 16'd1;

      // Every IO beat counts as a grant, so the starvation count restarts after a burst.
      if (w_io_start || w_in_burst)
        r_wait_cnt <= '0;
      else if (i_io_req && (r_wait_cnt < WAIT_MAX))
        r_wait_cnt <= r_wait_cnt + WW'(1);

      case (r_state)
        S_IDLE: begin
          if (w_io_start && (i_io_len != 2'd0)) begin
            r_state <= S_IO_BURST;
            r_beat  <= 2'd1;
            r_len   <= i_io_len;
            r_base  <= i_io_addr;
            r_we    <= i_io_we;
          end
        end
        S_IO_BURST: begin
          if (r_beat == r_len) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// Directed bench for pipe_dmem_arbiter: inputs change and outputs are checked on
// the falling edge; a second instance with IO_MAX_WAIT=0 exercises counter saturation.
module tb_pipe_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata, mem_rdata;
  logic [1:0]  io_len;
  logic        cpu_stall, cpu_rvalid, io_ack, io_done, io_rvalid, mem_we;
  logic [31:0] cpu_rdata, io_rdata, mem_addr, mem_wdata;
  logic [15:0] cpu_conflicts;

  logic        s_rst;
  logic        s_cpu_stall, s_cpu_rvalid, s_io_ack, s_io_done, s_io_rvalid, s_mem_we;
  logic [31:0] s_cpu_rdata, s_io_rdata, s_mem_addr, s_mem_wdata;
  logic [15:0] s_conflicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_dmem_arbiter #(.IO_MAX_WAIT(4)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_stall(cpu_stall), .o_cpu_rdata(cpu_rdata), .o_cpu_rvalid(cpu_rvalid),
    .i_io_req(io_req), .i_io_we(io_we), .i_io_addr(io_addr), .i_io_len(io_len),
    .i_io_wdata(io_wdata), .o_io_ack(io_ack), .o_io_done(io_done),
    .o_io_rdata(io_rdata), .o_io_rvalid(io_rvalid),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_cpu_conflicts(cpu_conflicts)
  );

  pipe_dmem_arbiter #(.IO_MAX_WAIT(0)) u_sat (
    .i_clk(clk), .i_rst(s_rst),
    .i_cpu_req(1'b1), .i_cpu_we(1'b0), .i_cpu_addr(32'h0), .i_cpu_wdata(32'h0),
    .o_cpu_stall(s_cpu_stall), .o_cpu_rdata(s_cpu_rdata), .o_cpu_rvalid(s_cpu_rvalid),
    .i_io_req(1'b1), .i_io_we(1'b1), .i_io_addr(32'h1000), .i_io_len(2'd3),
    .i_io_wdata(32'h0), .o_io_ack(s_io_ack), .o_io_done(s_io_done),
    .o_io_rdata(s_io_rdata), .o_io_rvalid(s_io_rvalid),
    .o_mem_we(s_mem_we), .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata),
    .i_mem_rdata(32'h0), .o_cpu_conflicts(s_conflicts)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
  endfunction

  // Memory returns read data one cycle after the address.
  always @(posedge clk) mem_rdata <= mdata(mem_addr);

  task automatic clear_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_we = 0; io_addr = 0; io_len = 0; io_wdata = 0;
  endtask

  task automatic test_reset;
    rst = 1; s_rst = 1; clear_inputs();
    repeat (2) @(negedge clk);
    cpu_req = 1; io_req = 1; io_len = 2'd3;
    #1;
    checks++; if (io_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", io_ack); end
    checks++; if (io_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", io_done); end
    checks++; if ({cpu_rvalid, io_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {cpu_rvalid, io_rvalid}); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if (cpu_conflicts !== 16'd0) begin errors++; $display("FAIL rst_conflicts got %h exp 0", cpu_conflicts); end
    // First grant on the release cycle: single-beat IO read.
    @(negedge clk);
    rst = 0; cpu_req = 0; io_req = 1; io_we = 0; io_addr = 32'h80; io_len = 2'd0;
    #1;
    checks++; if ({io_ack, io_done} !== 2'b11) begin errors++; $display("FAIL rel_ack_done got %b exp 11", {io_ack, io_done}); end
    checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL rel_addr got %h exp 00000080", mem_addr); end
    @(negedge clk);
    io_req = 0;
    #1;
    checks++; if ({io_rvalid, cpu_rvalid} !== 2'b10) begin errors++; $display("FAIL rel_rvalid got %b exp 10", {io_rvalid, cpu_rvalid}); end
    checks++; if (io_rdata !== mdata(32'h80)) begin errors++; $display("FAIL rel_rdata got %h exp %h", io_rdata, mdata(32'h80)); end
  endtask

  task automatic test_cpu_access;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall got %b exp 0", cpu_stall); end
    checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_port got %h/%b exp 00000010/0", mem_addr, mem_we); end
    @(negedge clk);
    cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || io_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rvalid got %b/%b exp 1/0", cpu_rvalid, io_rvalid); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rdata got %h exp deadbeef", cpu_rdata); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL cpu_wr_port got %b/%h exp 1/12345678", mem_we, mem_wdata); end
    @(negedge clk);
    cpu_req = 0; cpu_we = 0;
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_wr_rvalid got %b exp 0", cpu_rvalid); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL idle_port got %b/%h/%h exp 0/0/0", mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_io_burst;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      io_req = (n == 0); io_we = 0; io_addr = 32'h100; io_len = 2'd3;
      #1;
      checks++; if (io_ack !== (n <= 3)) begin errors++; $display("FAIL burst_ack[%0d] got %b exp %b", n, io_ack, n <= 3); end
      checks++; if (io_done !== (n == 3)) begin errors++; $display("FAIL burst_done[%0d] got %b exp %b", n, io_done, n == 3); end
      checks++; if (io_rvalid !== (n >= 1)) begin errors++; $display("FAIL burst_rvalid[%0d] got %b exp %b", n, io_rvalid, n >= 1); end
      checks++; if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL burst_cpu[%0d] got %b/%b exp 0/0", n, cpu_stall, cpu_rvalid); end
      if (n <= 3) begin
        checks++; if (mem_addr !== 32'h100 + 32'(4 * n)) begin errors++; $display("FAIL burst_addr[%0d] got %h exp %h", n, mem_addr, 32'h100 + 32'(4 * n)); end
      end
      if (n >= 1) begin
        checks++; if (io_rdata !== mdata(32'h100 + 32'(4 * (n - 1)))) begin errors++; $display("FAIL burst_rdata[%0d] got %h exp %h", n, io_rdata, mdata(32'h100 + 32'(4 * (n - 1)))); end
      end
    end
  endtask

  task automatic test_wrap;
    for (int n = 0; n <= 2; n++) begin
      @(negedge clk);
      io_req = (n == 0); io_we = 1; io_addr = 32'hFFFF_FFFC; io_len = 2'd1;
      io_wdata = 32'hA000_0000 + 32'(n);
      #1;
      if (n <= 1) begin
        checks++; if (mem_addr !== (n == 0 ? 32'hFFFF_FFFC : 32'h0)) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", n, mem_addr, (n == 0 ? 32'hFFFF_FFFC : 32'h0)); end
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hA000_0000 + 32'(n)) begin errors++; $display("FAIL wrap_wr[%0d] got %b/%h exp 1/%h", n, mem_we, mem_wdata, 32'hA000_0000 + 32'(n)); end
        checks++; if (io_done !== (n == 1)) begin errors++; $display("FAIL wrap_done[%0d] got %b exp %b", n, io_done, n == 1); end
      end
      checks++; if (io_rvalid !== 1'b0) begin errors++; $display("FAIL wrap_rvalid[%0d] got %b exp 0", n, io_rvalid); end
    end
    io_we = 0;
  endtask

  task automatic test_arbitration;
    logic exp_io;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
      io_req = 1; io_we = 0; io_addr = 32'h200; io_len = 2'd3;
      #1;
      exp_io = (c >= 5) && (c <= 8);
      checks++; if (io_ack !== exp_io || cpu_stall !== exp_io) begin errors++; $display("FAIL arb_grant[%0d] got ack %b stall %b exp %b", c, io_ack, cpu_stall, exp_io); end
      checks++; if (mem_addr !== (exp_io ? 32'h200 + 32'(4 * (c - 5)) : 32'h40)) begin errors++; $display("FAIL arb_addr[%0d] got %h exp %h", c, mem_addr, (exp_io ? 32'h200 + 32'(4 * (c - 5)) : 32'h40)); end
      checks++; if (io_done !== (c == 8)) begin errors++; $display("FAIL arb_done[%0d] got %b exp %b", c, io_done, c == 8); end
      if (c == 5) begin
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== mdata(32'h40)) begin errors++; $display("FAIL arb_cpu_ret got %b/%h exp 1/%h", cpu_rvalid, cpu_rdata, mdata(32'h40)); end
      end
      if (c == 6) begin
        checks++; if (io_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL arb_io_ret got %b/%b exp 1/0", io_rvalid, cpu_rvalid); end
      end
      if (c == 9) begin
        checks++; if (cpu_conflicts !== 16'd4) begin errors++; $display("FAIL arb_conflicts got %0d exp 4", cpu_conflicts); end
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || io_rvalid !== 1'b0) begin errors++; $display("FAIL arb_gap_ret got %b/%b exp 1/0", cpu_rvalid, io_rvalid); end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    io_req = 1; io_we = 0; io_addr = 32'h300; io_len = 2'd3;
    #1;
    checks++; if (io_ack !== 1'b1) begin errors++; $display("FAIL rmb_beat0 got %b exp 1", io_ack); end
    @(negedge clk);
    io_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h60;
    #1;
    checks++; if (io_ack !== 1'b1 || cpu_stall !== 1'b1 || mem_addr !== 32'h304) begin errors++; $display("FAIL rmb_beat1 got %b/%b/%h exp 1/1/00000304", io_ack, cpu_stall, mem_addr); end
    #1 rst = 1;
    #1;
    checks++; if (io_ack !== 1'b0 || io_done !== 1'b0) begin errors++; $display("FAIL rmb_ack got %b/%b exp 0/0", io_ack, io_done); end
    checks++; if (cpu_conflicts !== 16'd0) begin errors++; $display("FAIL rmb_conflicts got %0d exp 0", cpu_conflicts); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmb_mem_we got %b exp 0", mem_we); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (cpu_stall !== 1'b0 || mem_addr !== 32'h60 || io_ack !== 1'b0) begin errors++; $display("FAIL rmb_cpu_grant got %b/%h/%b exp 0/00000060/0", cpu_stall, mem_addr, io_ack); end
    checks++; if (io_rvalid !== 1'b0) begin errors++; $display("FAIL rmb_rvalid got %b exp 0", io_rvalid); end
    @(negedge clk);
    cpu_req = 0;
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== mdata(32'h60)) begin errors++; $display("FAIL rmb_cpu_ret got %b/%h exp 1/%h", cpu_rvalid, cpu_rdata, mdata(32'h60)); end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    s_rst = 0;
    repeat (65534) @(negedge clk);
    #1;
    checks++; if (s_conflicts !== 16'hFFFE || s_cpu_stall !== 1'b1) begin errors++; $display("FAIL sat_pre got %h/%b exp fffe/1", s_conflicts, s_cpu_stall); end
    @(negedge clk);
    #1;
    checks++; if (s_conflicts !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got %h exp ffff", s_conflicts); end
    repeat (4466) @(negedge clk);
    #1;
    checks++; if (s_conflicts !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", s_conflicts); end
  endtask

  initial begin
    test_reset();
    test_cpu_access();
    test_io_burst();
    test_wrap();
    test_arbitration();
    test_reset_mid_burst();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
